// File: rtl/dcache_ahb_sram_slave.sv
// AHB-Lite responder backed by a word-organised SRAM array.
// It adds a fixed number of wait states to every OKAY data phase and answers illegal transfers with ERROR.
module dcache_ahb_sram_slave #(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int ADDR_LENGTH = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hsel_i,
    input  logic [ADDR_LENGTH-1:0] haddr_i,
    input  logic [1:0]             htrans_i,
    input  logic                   hwrite_i,
    input  logic [2:0]             hsize_i,
    input  logic [2:0]             hburst_i,
    input  logic [3:0]             hprot_i,
    input  logic [WORD_SIZE-1:0]   hwdata_i,
    input  logic                   hready_i,
    output logic                   hreadyout_o,
    output logic [WORD_SIZE-1:0]   hrdata_o,
    output logic                   hresp_o
);
    localparam int BYTES  = WORD_SIZE / 8;
    localparam int OFFSET = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int IDX_W  = MEM_AW - OFFSET;
    localparam int DEPTH  = MEM_BYTES / BYTES;

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          waitCnt_q, waitCnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic                   accept;
    logic                   transferErr;
    logic [ADDR_LENGTH-1:0] alignMask;
    logic                   completion;
    logic                   slaveReady;
    logic [IDX_W-1:0]       memIdx;
    int                     laneOff;
    logic [BYTES-1:0]       byteEn;
    logic                   unusedBits;

    assign unusedBits = ^{hburst_i, hprot_i};

    assign accept      = hsel_i && htrans_i[1] && hready_i;
    assign alignMask   = (ADDR_LENGTH'(1) << hsize_i) - ADDR_LENGTH'(1);
    assign transferErr = (64'(haddr_i) >= 64'(MEM_BYTES))
                       || (hsize_i > 3'(OFFSET))
                       || (|(haddr_i & alignMask));

    assign completion = (state_q == DATA) && (waitCnt_q == 4'd0);
    assign memIdx     = addr_q[MEM_AW-1:OFFSET];
    assign laneOff    = int'(addr_q) % BYTES;

    // Lanes sharing the access's size-aligned group are the ones written.
    always_comb begin
        byteEn = '0;
        for (int b = 0; b < BYTES; b++) begin
            byteEn[b] = ((b >> size_q) == (laneOff >> size_q));
        end
    end

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        slaveReady = 1'b1;
        hresp_o    = 1'b0;

        case (state_q)
            IDLE: begin
                slaveReady = 1'b1;
            end
            DATA: begin
                slaveReady = (waitCnt_q == 4'd0);
                if (waitCnt_q != 4'd0) begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ERR1: begin
                slaveReady = 1'b0;
                hresp_o    = 1'b1;
                state_d    = ERR2;
            end
            ERR2: begin
                hresp_o = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A ready cycle closes the current phase, so the next one is picked by this cycle's accept.
        if (slaveReady) begin
            if (accept) begin
                addr_d    = haddr_i[MEM_AW-1:0];
                write_d   = hwrite_i;
                size_d    = hsize_i;
                waitCnt_d = 4'(WAIT_STATES);
                state_d   = transferErr ? ERR1 : DATA;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign hreadyout_o = slaveReady;
    assign hrdata_o    = (completion && !write_q) ? mem_q[memIdx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            size_q    <= size_d;
        end
    end

    // The array is deliberately not reset; a write commits only at its completion edge.
    always_ff @(posedge clk) begin
        if (completion && write_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteEn[b]) begin
                    mem_q[memIdx][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_ahb_sram_slave.sv
// Bench for dcache_ahb_sram_slave: one instance with one wait state and one with none, sharing a single AHB driver.
// A cycle-level response-schedule model plus a byte-array memory predicts every output cycle.
module tb_dcache_ahb_sram_slave;
    localparam logic [1:0] IDLE_T   = 2'b00;
    localparam logic [1:0] BUSY_T   = 2'b01;
    localparam logic [1:0] NONSEQ_T = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        useZero;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;

    logic        readyOne, respOne, readyZero, respZero;
    logic [31:0] rdataOne, rdataZero;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;

    int totalChecks = 0;
    int badChecks   = 0;

    assign hreadyout = useZero ? readyZero : readyOne;
    assign hresp     = useZero ? respZero  : respOne;
    assign hrdata    = useZero ? rdataZero : rdataOne;

    dcache_ahb_sram_slave #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n), .hsel_i(hsel && !useZero), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
        .hprot_i(hprot), .hwdata_i(hwdata), .hready_i(hreadyout),
        .hreadyout_o(readyOne), .hrdata_o(rdataOne), .hresp_o(respOne)
    );

    dcache_ahb_sram_slave #(.WAIT_STATES(0)) dutZero (
        .clk(clk), .rst_n(rst_n), .hsel_i(hsel && useZero), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
        .hprot_i(hprot), .hwdata_i(hwdata), .hready_i(hreadyout),
        .hreadyout_o(readyZero), .hrdata_o(rdataZero), .hresp_o(respZero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name, input int waited);
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL %s: waited %0d cycles for hreadyout, required fewer than 40", name, waited);
    endtask

    // Holds one address phase until the slave is ready, then drives its write data in the data phase.
    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hburst = 3'($urandom_range(7));
        hprot  = 4'($urandom_range(15));
        guard  = 0;
        while (!hreadyout && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) reportTimeout("stimTimeout", guard);
        @(negedge clk);
        if (sel && trans[1] && wr) hwdata = wdata;
    endtask

    task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected,
                             input int expWaits);
        int waits;
        applyStimulus(1'b1, NONSEQ_T, 1'b0, 3'd2, addr, 32'h0);
        hsel   = 1'b0;
        htrans = IDLE_T;
        waits  = 0;
        while (!hreadyout && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 40) reportTimeout("readTimeout", waits);
        checkOutput(name, hrdata, expected);
        checkOutput({name, "Waits"}, 32'(waits), 32'(expWaits));
        checkOutput({name, "Resp"}, 32'(hresp), 32'h0);
    endtask

    task automatic errCheck(input string name, input logic wr, input logic [2:0] size, input logic [31:0] addr);
        applyStimulus(1'b1, NONSEQ_T, wr, size, addr, 32'hFFFF_FFFF);
        hsel   = 1'b0;
        htrans = IDLE_T;
        checkOutput({name, "Ready1"}, 32'(hreadyout), 32'h0);
        checkOutput({name, "Resp1"}, 32'(hresp), 32'h1);
        @(negedge clk);
        checkOutput({name, "Ready2"}, 32'(hreadyout), 32'h1);
        checkOutput({name, "Resp2"}, 32'(hresp), 32'h1);
    endtask

    // One entry per future output cycle; an empty schedule means an idle OKAY cycle.
    typedef struct {
        bit          ready;
        bit          resp;
        bit          done;
        bit          wr;
        int unsigned addr;
        int unsigned size;
    } beat_t;

    beat_t      sched[$];
    logic [7:0] memModel [2][4096];
    bit         known [2][4096];

    initial begin
        beat_t       cur;
        logic [31:0] expData;
        bit          dataKnown;
        bit          err;
        int unsigned base;
        int          idx;
        int          ws;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sched.delete();
            end else begin
                idx = useZero ? 1 : 0;
                ws  = useZero ? 0 : 1;
                if (sched.size() > 0) cur = sched.pop_front();
                else cur = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
                base      = cur.addr & ~32'h3;
                expData   = '0;
                dataKnown = 1'b1;
                if (cur.done && !cur.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!known[idx][base + b]) dataKnown = 1'b0;
                        expData[8*b +: 8] = memModel[idx][base + b];
                    end
                end
                checkOutput("cmpReady", 32'(hreadyout), 32'(cur.ready));
                checkOutput("cmpResp", 32'(hresp), 32'(cur.resp));
                if (dataKnown) checkOutput("cmpData", hrdata, expData);
                checkOutput("otherIdle",
                            useZero ? {29'd0, readyOne, respOne, |rdataOne} : {29'd0, readyZero, respZero, |rdataZero},
                            32'h4);
                if (cur.done && cur.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if ((base + b) >= cur.addr && (base + b) < cur.addr + (32'd1 << cur.size)) begin
                            memModel[idx][base + b] = hwdata[8*b +: 8];
                            known[idx][base + b]    = 1'b1;
                        end
                    end
                end
                if (cur.ready && hsel && htrans[1]) begin
                    err = (haddr >= 32'd4096) || (hsize > 3'd2) || ((haddr % (32'd1 << hsize)) != 0);
                    if (err) begin
                        sched.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 0});
                        sched.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0, 0});
                    end else begin
                        for (int w = 0; w < ws; w++) sched.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
                        sched.push_back('{1'b1, 1'b0, 1'b1, hwrite, haddr, 32'(hsize)});
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        useZero = 1'b0;
        hsel    = 1'b0;
        htrans  = IDLE_T;
        hwrite  = 1'b0;
        hsize   = 3'd2;
        haddr   = '0;
        hburst  = '0;
        hprot   = '0;
        hwdata  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstReady", 32'(hreadyout), 32'h1);
        checkOutput("rstResp", 32'(hresp), 32'h0);
        checkOutput("rstData", hrdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // A write interrupted by reset during its wait state must never reach the array.
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h10, 32'h1234_5678);
        hsel   = 1'b0;
        htrans = IDLE_T;
        checkOutput("midData", 32'(hreadyout), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstReady", 32'(hreadyout), 32'h1);
        checkOutput("asyncRstResp", 32'(hresp), 32'h0);
        checkOutput("asyncRstData", hrdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readCheck("rd10", 32'h10, 32'hCAFE_F00D, 1);

        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
        hsel   = 1'b0;
        htrans = IDLE_T;
        checkOutput("wr20Wait", 32'(hreadyout), 32'h0);
        @(negedge clk);
        checkOutput("wr20Done", 32'(hreadyout), 32'h1);
        readCheck("rd20", 32'h20, 32'hDEAD_BEEF, 1);

        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h40, 32'h1122_3344);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd0, 32'h41, 32'h5555_AA55);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd1, 32'h42, 32'hBEEF_1234);
        readCheck("rd40", 32'h40, 32'hBEEF_AA44, 1);

        errCheck("errRange", 1'b0, 3'd2, 32'h1000);
        errCheck("errAlign", 1'b1, 3'd1, 32'h41);
        readCheck("rd40Kept", 32'h40, 32'hBEEF_AA44, 1);
        errCheck("errSize", 1'b0, 3'd3, 32'h48);
        readCheck("rdFromErr2", 32'h20, 32'hDEAD_BEEF, 1);

        hwdata = 32'h0BAD_0BAD;
        applyStimulus(1'b1, BUSY_T, 1'b1, 3'd2, 32'h40, 32'h0);
        checkOutput("busyReady", 32'(hreadyout), 32'h1);
        applyStimulus(1'b0, NONSEQ_T, 1'b1, 3'd2, 32'h40, 32'h0);
        checkOutput("noSelReady", 32'(hreadyout), 32'h1);
        applyStimulus(1'b1, IDLE_T, 1'b1, 3'd2, 32'h20, 32'h0);
        checkOutput("idleResp", 32'(hresp), 32'h0);
        readCheck("rd40Ignored", 32'h40, 32'hBEEF_AA44, 1);
        readCheck("rd20Ignored", 32'h20, 32'hDEAD_BEEF, 1);

        hsel   = 1'b0;
        htrans = IDLE_T;
        @(negedge clk);
        useZero = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h0, 32'h0000_0001);
        readCheck("b2bRead", 32'h0, 32'h0000_0001, 0);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd2, 32'h4, 32'hA5A5_5A5A);
        applyStimulus(1'b1, NONSEQ_T, 1'b1, 3'd0, 32'h7, 32'h3C00_0000);
        readCheck("b2bByte", 32'h4, 32'h3CA5_5A5A, 0);
        errCheck("errRangeZero", 1'b1, 3'd2, 32'hFFFF_F000);
        readCheck("rdZeroFromErr2", 32'h0, 32'h0000_0001, 0);

        hsel   = 1'b0;
        htrans = IDLE_T;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule

// File: doc/dcache_ahb_sram_slave.md
Name: dcache_ahb_sram_slave

Overview:
AHB-Lite responder backed by an internal word-organised SRAM array. It is the memory end of the data cache's AHB master port: it serves cache refills and write transfers, and inserts a programmable number of wait states so the cache miss path can be exercised. It detects illegal transfers and answers them with the two-cycle AHB ERROR response; it is used in bench and standalone tile configurations.

Parameters:
WORD_SIZE, 32, data bus width in bits (multiple of 8).
MEM_BYTES, 4096, memory size in bytes (power of two); valid byte addresses are 0..MEM_BYTES-1.
ADDR_LENGTH, 32, haddr width.
WAIT_STATES, 1, wait cycles inserted in every OKAY data phase (0..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
hsel  in  1  slave select.
haddr  in  ADDR_LENGTH  transfer address.
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
hwrite  in  1  1 = write.
hsize  in  3  transfer size (log2 bytes).
hburst  in  3  ignored; every beat is treated as an independent transfer.
hprot  in  4  ignored.
hwdata  in  WORD_SIZE  write data, valid in the data phase.
hready  in  1  bus-level HREADY (previous transfer complete).
hreadyout  out  1  slave ready.
hrdata  out  WORD_SIZE  read data.
hresp  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async, any state): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait_cnt=0, captured address-phase registers cleared. Any pending write is dropped. SRAM contents are not reset and are undefined after power-up.
- Accept: at a rising edge where hsel && htrans[1] && hready. On accept, register addr, write, size and err_pending.
- Ignored transfers: IDLE/BUSY, or hsel=0, are not accepted and receive a zero-wait OKAY (hreadyout=1, hresp=0).
- Error conditions, evaluated at accept:
  - haddr >= MEM_BYTES.
  - hsize > log2(WORD_SIZE/8).
  - Misaligned access: any of the haddr[hsize-1:0] bits set.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE:
  - hreadyout=1, hresp=0.
  - Accept with error goes to ERR1.
  - Accept without error goes to DATA, with wait_cnt loaded to WAIT_STATES.
- DATA:
  - hreadyout = (wait_cnt==0), hresp=0.
  - While wait_cnt != 0, decrement it each cycle; inputs other than hwdata are ignored.
  - Completion is the cycle with hreadyout=1:
    - Read: hrdata = the full memory word at addr[log2(MEM_BYTES)-1:OFFSET]; the master selects byte lanes.
    - Write: the enabled byte lanes of hwdata are written at the closing edge.
  - Byte enables by size:
    - Byte: lane addr[OFFSET-1:0].
    - Halfword: the lane pair selected by addr[OFFSET-1:1].
    - Word: all lanes.
  - Next state is chosen by the accept in the same completion cycle (back-to-back pipelining):
    - error accept goes to ERR1;
    - clean accept stays in DATA, wait_cnt reloaded;
    - no accept goes to IDLE.
- ERR1: hreadyout=0, hresp=1, no memory access. Next state is ERR2 unconditionally.
- ERR2: hreadyout=1, hresp=1. The accept rules apply as in IDLE; the next state is ERR1, DATA or IDLE accordingly.
- hrdata is 0 in every cycle except a read completion cycle.
- Write data hazard: with WAIT_STATES=0, a read accepted in a write's completion cycle returns the newly written data in the next cycle. Write-first ordering is guaranteed because the write commits at the edge before the read's data phase.
- Read latency from accept edge to data: WAIT_STATES+1 cycles. Throughput: one transfer per WAIT_STATES+1 cycles.
- Address bits above log2(MEM_BYTES) are used only for the range check.

Test Plan:
- Reset values: assert rst_n=0 mid-DATA with wait_cnt=1 -> hreadyout=1, hresp=0 and hrdata=0 immediately. The interrupted write to 0x10 is not committed: a later read of 0x10 returns its pre-reset value.
- Word write then read, WAIT_STATES=1:
  - NONSEQ write 0x20 with hwdata=0xDEADBEEF -> hreadyout is 0 for one cycle, then 1.
  - NONSEQ read 0x20 -> hrdata=0xDEADBEEF in the hreadyout=1 cycle, 2 cycles after accept, hresp=0.
- Sub-word writes:
  - word 0x11223344 at 0x40;
  - byte write 0xAA at 0x41;
  - halfword write 0xBEEF at 0x42;
  - read 0x40 -> 0xBEEFAA44.
- Errors:
  - read 0x1000 (out of range) -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1;
  - halfword write at 0x41 -> same two-cycle ERROR and memory at 0x40 unchanged;
  - hsize=3 -> ERROR.
- Back-to-back, WAIT_STATES=0: write 0x0=0x1 and a read of 0x0 on consecutive cycles -> read completes the cycle after its accept with hrdata=0x1, no bubble.
- IDLE/BUSY/hsel=0 cycles interleaved, plus an accept in ERR2 -> each ignored cycle gives hreadyout=1/hresp=0 with no memory change. The accept in ERR2 enters DATA and completes OKAY.
